synth_top: RTL and testbench
============================

// Module: synth_top
// PURPOSE
//   Top level of the tone synthesiser. Runs from the 100 MHz board clock.
//   Generates a fixed-frequency sine tone from an 8-bit phase accumulator and a sine lookup.
//   Streams the tone to an external I2S DAC (Pmod-style MCLK/LRCK/SCK/SDOUT), the same sample on both channels.
//   Shows the current sample on the board LEDs and exports phase/sample for debug.
// PARAMETERS
//   PHASE_STEP  8'd5   phase increment per audio frame (tone freq = PHASE_STEP*97656.25/256 Hz)
//   DIV_W       10     frame-divider width; frame = 2**DIV_W clk cycles
// PORTS
//   rst    in   1  asynchronous reset, active-low (rst=0 resets all state)
//   clk    in   1  100 MHz system clock; the only clock, all flops on posedge
//   led    out  8  mirror of s
//   mclk   out  1  DAC master clock, clk/4 = 25 MHz
//   lrck   out  1  word select, clk/1024 = 97.656 kHz; 0=left, 1=right
//   sck    out  1  serial bit clock, clk/16 = 6.25 MHz (64 sck per frame)
//   sdout  out  1  I2S serial data
//   phase  out  8  phase accumulator
//   s      out  8  current unsigned sample (128 = midscale)
// BEHAVIOUR
//   - div[9:0]: free-running counter, +1 every clk, wraps 1023->0.
//   - mclk=div[1], sck=div[3], lrck=div[9], all taken straight from register bits (glitch-free).
//   - Reset (rst=0): div=0, phase=0, s=128, led=128, sdout=0, tx word=0.
//     All outputs except sdout follow combinationally from those registers.
//     Release of reset restarts the frame at div=0.
//   - Phase: at the clk edge where div==1023, phase <= phase+PHASE_STEP, mod 256 wrap.
//     Phase holds constant for the whole frame.
//   - Sample: s <= sine(phase) registered every clk, so s is valid 1 clk after a phase change.
//   - sine(p) = round(127.5 + 127.5*sin(2*pi*p/256)), range 0..255.
//     sine(0)=128, sine(64)=255, sine(128)=128, sine(192)=0.
//   - TX word: at div==15, latch w[23:0] = {~s[7], s[6:0], 16'h0000}.
//     This is two's-complement 24-bit, MSB-justified.
//     The same w is used for the left half (lrck=0) and the right half (lrck=1) of the frame.
//   - Serial timing: 32 sck per half-frame. Let k = div[8:4] be the sck index within the half.
//     sdout changes only on sck falling edges (div[3:0]==0).
//     I2S framing: the MSB appears one sck after each lrck edge.
//     sdout = w[24-k] for k in 1..24; sdout = 0 for k==0 and for k in 25..31.
//     sdout is registered, computed from the next div value so it updates on the same clk edge as sck falls.
//   - DAC samples sdout on sck rising edge.
//   - Latency: a phase change reaches sdout in the next frame's left MSB.
//     The word is latched at div==15 of the frame in which the phase changed.
//   - Reset mid-frame: all outputs return to reset values immediately (asynchronous).
//     No partial word is completed.
// STRUCTURE
//   - synth_pkg: DIV_W, bit-index constants (MSB_SLOT=1, LSB_SLOT=24), sine_q function/table.
//     The table is quarter-wave, 64 entries, with symmetry folding giving 256 points.
//   - One sub-module, i2s_tx.
//     Inputs: clk, rst, div, 24-bit sample word.
//     Outputs: mclk, sck, lrck, sdout.
//     Contains the word latch and the serialiser.
//   - synth_top holds div, phase, the sine lookup, s and led.
// TESTING
//   - Reset: hold rst=0 for 4 clk -> div=0, phase=0, s=led=128, mclk=sck=lrck=sdout=0.
//   - Clocks after release: mclk period 4 clk, sck period 16 clk, lrck period 1024 clk.
//     All at 50% duty; lrck rises at div=512.
//   - Phase step: after 3 frames phase=15 (PHASE_STEP=5), wrapping 255->4 at frame 52.
//     s equals sine(phase) 1 clk after each change.
//   - Serial word: with phase forced to 64 (s=255), w=24'h7F0000.
//     sdout=0 in slot 0, then bits 0,1,1,1,1,1,1,1, then 16 zeros in slots 1..24, and 0 in slots 25..31.
//     Identical in the left and right halves.
//   - Midscale: phase=0 or 128 (s=128) -> w=24'h000000 -> sdout held 0 all frame.
//     phase=192 (s=0) -> w=24'h800000, MSB slot is 1.
//   - Async reset mid-frame at div=300 -> outputs reset within the same cycle.
//     After release, the first lrck rise is 512 clk later.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and the sine lookup for the tone synthesiser.
//   DIV_W_DEF  : default frame-divider width (frame = 2**DIV_W clk cycles)
//   WORD_W     : serial word width sent to the DAC
//   MSB_SLOT / LSB_SLOT : sck slots (within a half-frame) carrying word bits
//   LATCH_DIV  : divider value at which the TX word is captured
//   sine_q()   : 8-bit unsigned sine, 256 points folded from a 64-entry quarter wave
package synth_pkg;

    localparam int         DIV_W_DEF = 10;
    localparam int         WORD_W    = 24;
    localparam int         MSB_SLOT  = 1;
    localparam int         LSB_SLOT  = 24;
    localparam int         LATCH_DIV = 15;
    localparam logic [7:0] MIDSCALE  = 8'd128;

    // round(127.5 + 127.5*sin(2*pi*i/256)) for i = 0..63
    localparam logic [0:63][7:0] SINE_LUT = {
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
        8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
        8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
        8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    // Quarter-wave lookup over 0..64 inclusive; the peak (64) sits one past
    // the end of the table, so it is supplied directly.
    function automatic logic [7:0] quarter_wave(input logic [6:0] j);
        if (j[6]) return 8'd255;
        return SINE_LUT[j[5:0]];
    endfunction

    // Second and fourth quadrants mirror the index; the lower half-wave is
    // 255 minus the upper one. Phase 128 is the exception: 127.5 rounds up to
    // 128 on both halves, so it cannot come from the 255-x reflection.
    function automatic logic [7:0] sine_q(input logic [7:0] p);
        logic [6:0] fwd;
        logic [6:0] rev;
        logic [7:0] v;
        fwd = {1'b0, p[5:0]};
        rev = 7'd64 - fwd;
        case (p[7:6])
            2'd0:    v = quarter_wave(fwd);
            2'd1:    v = quarter_wave(rev);
            2'd2:    v = (p[5:0] == 6'd0) ? MIDSCALE : 8'd255 - quarter_wave(fwd);
            default: v = 8'd255 - quarter_wave(rev);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/synth_i2s_tx.sv
// I2S transmitter: derives MCLK/SCK/LRCK from the frame divider, latches the
// 24-bit sample word once per frame and shifts it out MSB-first, one sck
// after each lrck edge, the same word in both halves.
//   clk   in  system clock
//   rst   in  asynchronous reset, active-low
//   div   in  free-running frame divider
//   word  in  24-bit two's-complement sample, MSB-justified
//   mclk  out div[1]
//   sck   out div[3]
//   lrck  out div[DIV_W-1] (0 = left, 1 = right)
//   sdout out registered serial data, changes as sck falls
module i2s_tx
    import synth_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    input  logic [WORD_W-1:0] word,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic              sdout
);

    localparam int SLOT_W = DIV_W - 5;

    logic [WORD_W-1:0] w_q, w_d;
    logic              sdout_q, sdout_d;
    logic [DIV_W-1:0]  div_nx;
    logic [SLOT_W-1:0] slot_nx;
    logic [4:0]        bit_idx;

    assign mclk  = div[1];
    assign sck   = div[3];
    assign lrck  = div[DIV_W-1];
    assign sdout = sdout_q;

    // sdout is computed from the value div takes after this edge, so the
    // register updates on the same edge that drops sck.
    assign div_nx  = div + DIV_W'(1);
    assign slot_nx = div_nx[DIV_W-2:4];
    assign bit_idx = 5'(LSB_SLOT) - 5'(slot_nx);

    always_comb begin
        w_d = w_q;
        if (div == DIV_W'(LATCH_DIV)) w_d = word;

        sdout_d = sdout_q;
        if (div_nx[3:0] == 4'd0) begin
            sdout_d = 1'b0;
            // The left MSB goes out on the latch edge itself, so read the
            // word being loaded rather than the stale register.
            if (slot_nx >= SLOT_W'(MSB_SLOT) && slot_nx <= SLOT_W'(LSB_SLOT))
                sdout_d = w_d[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q     <= '0;
            sdout_q <= 1'b0;
        end else begin
            w_q     <= w_d;
            sdout_q <= sdout_d;
        end
    end

endmodule

// File: rtl/synth_top.sv
// Tone synthesiser top: phase accumulator stepped once per audio frame, sine
// lookup into a registered 8-bit sample, and an I2S stream to the DAC.
//   rst   in  asynchronous reset, active-low
//   clk   in  100 MHz system clock
//   led   out mirror of s
//   mclk  out DAC master clock, clk/4
//   lrck  out word select, clk/1024
//   sck   out serial bit clock, clk/16
//   sdout out I2S serial data
//   phase out phase accumulator
//   s     out current unsigned sample (128 = midscale)
module synth_top
    import synth_pkg::*;
#(
    parameter logic [7:0] PHASE_STEP = 8'd5,
    parameter int         DIV_W      = DIV_W_DEF
) (
    input  logic       rst,
    input  logic       clk,
    output logic [7:0] led,
    output logic       mclk,
    output logic       lrck,
    output logic       sck,
    output logic       sdout,
    output logic [7:0] phase,
    output logic [7:0] s
);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [7:0]        phase_q, phase_d;
    logic [7:0]        s_q, s_d;
    logic [WORD_W-1:0] word;

    always_comb begin
        div_d   = div_q + DIV_W'(1);
        phase_d = phase_q;
        // Step on the last cycle of the frame so phase is flat for a whole frame.
        if (&div_q) phase_d = phase_q + PHASE_STEP;
        s_d = sine_q(phase_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            phase_q <= '0;
            s_q     <= MIDSCALE;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            s_q     <= s_d;
        end
    end

    // Offset binary to two's complement: flip the MSB, left-justify in 24 bits.
    assign word = {~s_q[7], s_q[6:0], 16'h0000};

    i2s_tx #(
        .DIV_W (DIV_W)
    ) u_i2s_tx (
        .clk   (clk),
        .rst   (rst),
        .div   (div_q),
        .word  (word),
        .mclk  (mclk),
        .sck   (sck),
        .lrck  (lrck),
        .sdout (sdout)
    );

    assign phase = phase_q;
    assign s     = s_q;
    assign led   = s_q;

endmodule

// File: tb/tb_synth_top.sv
// Directed bench for synth_top: one instance at the default step of 5, one at
// step 64 to reach the peak/midscale/trough samples within a few frames.
module tb_synth_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] led, phase, s;
    logic       mclk, lrck, sck, sdout;
    logic [7:0] led64, phase64, s64;
    logic       mclk64, lrck64, sck64, sdout64;

    synth_top u_dut (
        .rst(rst), .clk(clk), .led(led), .mclk(mclk), .lrck(lrck),
        .sck(sck), .sdout(sdout), .phase(phase), .s(s)
    );

    synth_top #(.PHASE_STEP(8'd64)) u_dut64 (
        .rst(rst), .clk(clk), .led(led64), .mclk(mclk64), .lrck(lrck64),
        .sck(sck64), .sdout(sdout64), .phase(phase64), .s(s64)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // I2S frame as seen at sck rising edges: slot 0 idle, 24 data bits, 7 idle, per half.
    function automatic logic [63:0] frame_bits(input logic [23:0] w);
        return {1'b0, w, 7'b0, 1'b0, w, 7'b0};
    endfunction

    // Hand-computed words: step 5 -> phases 0,5,10 -> s 128,143,158
    logic [23:0] w_main [0:2] = '{24'h000000, 24'h0F0000, 24'h1E0000};
    // step 64 -> phases 0,64,128,192 -> s 128,255,128,0
    logic [23:0] w_64   [0:3] = '{24'h000000, 24'h7F0000, 24'h000000, 24'h800000};

    initial begin
        logic [63:0] cap, cap64;
        logic [15:0] nb;
        int          f;
        int          cnt;

        cap   = '0;
        cap64 = '0;

        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", phase, 8'd0);
        chk("rst_s",     s,     8'd128);
        chk("rst_led",   led,   8'd128);
        chk("rst_clks",  {mclk, sck, lrck, sdout}, 4'b0000);
        chk("rst_s64",   s64,   8'd128);
        rst = 1'b1;

        for (int n = 1; n <= 52 * 1024 + 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            nb = 16'(n);
            if (n <= 1024)
                chk($sformatf("clkdiv n=%0d", n), {lrck, sck, mclk}, {nb[9], nb[3], nb[1]});
            if (nb[3:0] == 4'd8) begin
                cap   = {cap[62:0], sdout};
                cap64 = {cap64[62:0], sdout64};
            end
            if (nb[9:0] == 10'd1023) begin
                f = n / 1024;
                if (f <= 2) chk($sformatf("frame%0d", f), cap, frame_bits(w_main[f]));
                if (f <= 3) chk($sformatf("frame64_%0d", f), cap64, frame_bits(w_64[f]));
            end
            case (n)
                1024: begin
                    chk("phase_f1", phase, 8'd5);
                    chk("s_lag",    s,     8'd128);
                end
                1025: begin
                    chk("s_f1",    s,     8'd143);
                    chk("led_f1",  led,   8'd143);
                    chk("s64_f1",  s64,   8'd255);
                end
                1500: chk("phase_hold", phase, 8'd5);
                2049: begin
                    chk("s_f2",    s,     8'd158);
                    chk("s64_f2",  s64,   8'd128);
                end
                3072: begin
                    chk("phase_f3",   phase,   8'd15);
                    chk("phase64_f3", phase64, 8'd192);
                end
                3073: begin
                    chk("s_f3",     s,     8'd173);
                    chk("s64_f3",   s64,   8'd0);
                    chk("led64_f3", led64, 8'd0);
                end
                51 * 1024:     chk("phase_f51", phase, 8'd255);
                52 * 1024:     chk("phase_wrap", phase, 8'd4);
                52 * 1024 + 1: chk("s_wrap", s, 8'd140);
                default: ;
            endcase
        end

        // Divider now at 1; move to 300 and pull reset between edges.
        repeat (299) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_sck", sck, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_phase", phase, 8'd0);
        chk("mid_rst_s",     s,     8'd128);
        chk("mid_rst_led",   led,   8'd128);
        chk("mid_rst_clks",  {mclk, sck, lrck, sdout}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        cnt = 0;
        while (!lrck && cnt < 2000) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        chk("lrck_rise_after_rst", 64'(cnt), 64'd512);
        chk("phase_after_rst",     phase,    8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
